clk_en_gen: RTL and testbench

Parametrised clock-enable generator and reset sequencer that follows the system PLL. It supervises the PLL `lock` signal and holds a synchronous reset for the downstream logic until lock has been stable for a set time. In the run state it derives up to eight independent fractional clock enables from the single fast system clock, one phase accumulator per channel. Everything downstream (CPU, video, audio) therefore runs in one clock domain, gated by these enables, instead of needing one PLL output per rate.

---
 rtl/clk_en_gen.sv | 58 +++++
 tb/tb_clk_en_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// clk_en_gen: waits for stable PLL lock, then releases rst_out and emits CHANNELS fractional clock enables; ports clk, reset, lock, incr, sync (only with CLK_EN_SYNC_EN), ce, rst_out, running
module clk_en_gen #(
  parameter int CHANNELS = 3,
  parameter int ACC_W = 24,
  parameter int LOCK_HOLD = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      lock,
  input  logic [CHANNELS*ACC_W-1:0] incr,
`ifdef CLK_EN_SYNC_EN
  input  logic                      sync,
`endif
  output logic [CHANNELS-1:0]       ce,
  output logic                      rst_out,
  output logic                      running
);
  localparam int CW = $clog2(LOCK_HOLD);
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;
  state_t state, nxt;
  logic lock_m, lock_s, hold_done, realign, adv;
  logic [CW-1:0] cnt;
  logic [CHANNELS-1:0] carry;
  always_ff @(posedge clk)
    if (reset) {lock_s, lock_m} <= 2'b00;
    else {lock_s, lock_m} <= {lock_m, lock};
  assign hold_done = cnt == CW'(LOCK_HOLD - 1);
  always_comb
    nxt = !lock_s ? WAIT_LOCK : state == WAIT_LOCK ? SETTLE : state == SETTLE && !hold_done ? SETTLE : RUN;
`ifdef CLK_EN_SYNC_EN
  assign realign = sync && state == RUN;
`else
  assign realign = 1'b0;
`endif
  assign adv = nxt == RUN && !realign;
  always_ff @(posedge clk)
    if (reset) begin
      state <= WAIT_LOCK;
      cnt <= '0;
      rst_out <= 1'b1;
      running <= 1'b0;
      ce <= '0;
    end else begin
      state <= nxt;
      cnt <= state == SETTLE && nxt == SETTLE ? cnt + 1'b1 : '0;
      rst_out <= nxt != RUN;
      running <= nxt == RUN;
      ce <= adv ? carry : '0;
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0] sum;
    assign sum = {1'b0, acc} + {1'b0, incr[i*ACC_W +: ACC_W]};
    assign carry[i] = sum[ACC_W];
    always_ff @(posedge clk)
      acc <= reset || !adv ? '0 : sum[ACC_W-1:0];
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed self-checking bench for clk_en_gen
module tb_clk_en_gen;
  localparam int CH = 3, AW = 8, LH = 16;
  logic clk = 1'b0, reset = 1'b1, lock = 1'b0;
  logic [CH*AW-1:0] incr = '0;
`ifdef CLK_EN_SYNC_EN
  logic sync = 1'b0;
`endif
  logic [CH-1:0] ce;
  logic rst_out, running;
  int checks = 0, failures = 0;
  typedef struct {
    logic lock;
    logic [CH-1:0] ce;
    logic rst_out;
    logic running;
  } vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  clk_en_gen #(.CHANNELS(CH), .ACC_W(AW), .LOCK_HOLD(LH)) dut (
    .clk(clk),
    .reset(reset),
    .lock(lock),
    .incr(incr),
`ifdef CLK_EN_SYNC_EN
    .sync(sync),
`endif
    .ce(ce),
    .rst_out(rst_out),
    .running(running)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic expect_release(input int n, input string tag);
    int bad = 0;
    for (int k = 1; k < n; k++) begin
      tick();
      if (rst_out !== 1'b1 || running !== 1'b0 || ce !== '0) bad++;
    end
    chk({tag, " held"}, bad, 0);
    tick();
    chk({tag, " rst_out"}, rst_out, 0);
    chk({tag, " running"}, running, 1);
    chk({tag, " ce"}, ce, 0);
  endtask
  initial begin
    int c0, c1, c2, n, last, badgap, bad;
    tbl[0] = '{1'b1, 3'b001, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 3'b000, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 3'b011, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 3'b000, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 3'b001, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 3'b000, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 3'b011, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 3'b000, 1'b0, 1'b1};
    lock = 1'b1;
    incr = {8'd0, 8'd64, 8'd128};
    repeat (3) tick();
    chk("reset ce", ce, 0);
    chk("reset rst_out", rst_out, 1);
    chk("reset running", running, 0);
    reset = 1'b0;
    expect_release(3 + LH, "release");
    for (int k = 0; k < 8; k++) begin
      lock = tbl[k].lock;
      tick();
      chk($sformatf("vec%0d ce", k), ce, tbl[k].ce);
      chk($sformatf("vec%0d rst_out", k), rst_out, tbl[k].rst_out);
      chk($sformatf("vec%0d running", k), running, tbl[k].running);
    end
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      c0 += int'(ce[0]); c1 += int'(ce[1]); c2 += int'(ce[2]);
    end
    chk("rate ch0", c0, 128);
    chk("rate ch1", c1, 64);
    chk("rate ch2", c2, 0);
    incr = {8'd0, 8'd0, 8'd3};
    n = 0; last = -1; badgap = 0;
    for (int k = 0; k < 512; k++) begin
      tick();
      if (ce[0]) begin
        if (last >= 0 && k - last != 85 && k - last != 86) badgap++;
        last = k;
        n++;
      end
    end
    chk("frac count", n, 6);
    chk("frac spacing", badgap, 0);
    lock = 1'b0;
    tick();
    chk("loss running early", running, 1);
    tick();
    tick();
    chk("loss ce", ce, 0);
    chk("loss rst_out", rst_out, 1);
    chk("loss running", running, 0);
    repeat (3) tick();
    incr = {8'd255, 8'd0, 8'd128};
    lock = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rst_out !== 1'b1 || running !== 1'b0) bad++;
    end
    chk("glitch pre held", bad, 0);
    lock = 1'b0;
    tick();
    lock = 1'b1;
    expect_release(3 + LH, "glitch");
    tick();
    chk("realign r1", ce, 3'b101);
    tick();
    chk("realign r2", ce, 3'b100);
    tick();
    chk("realign r3", ce, 3'b101);
    reset = 1'b1;
    tick();
    chk("midrun reset ce", ce, 0);
    chk("midrun reset rst_out", rst_out, 1);
    chk("midrun reset running", running, 0);
    reset = 1'b0;
    expect_release(3 + LH, "rerelease");
`ifdef CLK_EN_SYNC_EN
    incr = {8'd128, 8'd128, 8'd128};
    repeat (5) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync edge ce", ce, 0);
    tick();
    chk("sync +1 ce", ce, 0);
    tick();
    chk("sync +2 ce", ce, 3'b111);
    tick();
    chk("sync +3 ce", ce, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
